// File: rtl/mult_div_unit_if.sv
// E-stage <-> MDU bundle: operation request plus the HI/LO/busy results.
interface mult_div_unit_if;
  logic        start;
  logic [3:0]  op;
  logic        flush;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, flush, a, b, input busy, hi, lo);
  modport slave  (input start, op, flush, a, b, output busy, hi, lo);
endinterface

// File: rtl/mult_div_unit.sv
// Fixed-latency multiply/divide unit owning the HI/LO registers.
// Optional feature macro: MDU_MADD_EN enables madd/maddu/msub/msubu (ops 7-10).
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic           clk,
  input  logic           reset,
  mult_div_unit_if.slave mdu
);

  localparam int unsigned DataW = 32;
  localparam int unsigned CntW  = 4;

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMthi  = 4'd5;
  localparam logic [3:0] OpMtlo  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OpMadd  = 4'd7;
  localparam logic [3:0] OpMaddu = 4'd8;
  localparam logic [3:0] OpMsub  = 4'd9;
  localparam logic [3:0] OpMsubu = 4'd10;
`endif

  typedef enum logic {IDLE, RUN} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic              busy_q;
  logic [DataW-1:0]  hi_q, lo_q, p_hi_q, p_lo_q;

  logic              run_d;
  logic [CntW-1:0]   lat_d;
  logic [DataW-1:0]  res_hi_d, res_lo_d;
  logic [2*DataW-1:0] prod_s, prod_u;
  logic              div_ovf, div_zero;
  logic [DataW-1:0]  b_safe;
  logic signed [DataW-1:0] quo_s, rem_s;
  logic [DataW-1:0]  quo_u, rem_u;

  // Result datapath: products, guarded divides and the op decode for a new start.
  always_comb begin
    run_d    = 1'b0;
    lat_d    = CntW'(MULT_CYCLES);
    res_hi_d = '0;
    res_lo_d = '0;
    prod_s   = $signed({{DataW{mdu.a[DataW-1]}}, mdu.a}) * $signed({{DataW{mdu.b[DataW-1]}}, mdu.b});
    prod_u   = {{DataW{1'b0}}, mdu.a} * {{DataW{1'b0}}, mdu.b};
    div_zero = (mdu.b == '0);
    div_ovf  = (mdu.a == 32'h8000_0000) && (mdu.b == 32'hFFFF_FFFF);
    // Divisor forced to 1 on the special cases so the divider never sees /0 or overflow.
    b_safe   = (div_zero || div_ovf) ? 32'd1 : mdu.b;
    quo_s    = $signed(mdu.a) / $signed(b_safe);
    rem_s    = $signed(mdu.a) % $signed(b_safe);
    quo_u    = mdu.a / b_safe;
    rem_u    = mdu.a % b_safe;
    case (mdu.op)
      OpMult:  begin run_d = 1'b1; {res_hi_d, res_lo_d} = prod_s; end
      OpMultu: begin run_d = 1'b1; {res_hi_d, res_lo_d} = prod_u; end
      OpDiv, OpDivu: begin
        run_d = 1'b1;
        lat_d = CntW'(DIV_CYCLES);
        if (div_zero) begin
          res_hi_d = mdu.a;
          res_lo_d = 32'hFFFF_FFFF;
        end else if (mdu.op == OpDiv && div_ovf) begin
          res_hi_d = '0;
          res_lo_d = 32'h8000_0000;
        end else if (mdu.op == OpDiv) begin
          res_hi_d = rem_s;
          res_lo_d = quo_s;
        end else begin
          res_hi_d = rem_u;
          res_lo_d = quo_u;
        end
      end
`ifdef MDU_MADD_EN
      OpMadd:  begin run_d = 1'b1; {res_hi_d, res_lo_d} = {hi_q, lo_q} + prod_s; end
      OpMaddu: begin run_d = 1'b1; {res_hi_d, res_lo_d} = {hi_q, lo_q} + prod_u; end
      OpMsub:  begin run_d = 1'b1; {res_hi_d, res_lo_d} = {hi_q, lo_q} - prod_s; end
      OpMsubu: begin run_d = 1'b1; {res_hi_d, res_lo_d} = {hi_q, lo_q} - prod_u; end
`endif
      default: begin end
    endcase
  end

  // Control FSM: capture result at start, count down, commit to HI/LO on 1->0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      p_hi_q  <= '0;
      p_lo_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mdu.start && !mdu.flush) begin
            if (run_d) begin
              p_hi_q  <= res_hi_d;
              p_lo_q  <= res_lo_d;
              cnt_q   <= lat_d;
              busy_q  <= 1'b1;
              state_q <= RUN;
            end else if (mdu.op == OpMthi) begin
              hi_q <= mdu.a;
            end else if (mdu.op == OpMtlo) begin
              lo_q <= mdu.a;
            end
          end
        end
        RUN: begin
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            hi_q    <= p_hi_q;
            lo_q    <= p_lo_q;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mdu.busy = busy_q;
  assign mdu.hi   = hi_q;
  assign mdu.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed + randomized scoreboard bench for mult_div_unit.
module tb_mult_div_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic [63:0] exp_q[$];
  logic [63:0] model_hilo;

  mult_div_unit_if mdu();

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (rst_n),
    .mdu   (mdu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Independent reference: integer arithmetic on 64-bit host types.
  function automatic logic [63:0] ref_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    int sa, sb;
    longint ps;
    longint unsigned pu;
    logic [31:0] q, r;
    sa = int'(a);
    sb = int'(b);
    case (op)
      4'd1: begin ps = longint'(sa) * longint'(sb); return 64'(ps); end
      4'd2: begin pu = 64'(a) * 64'(b); return pu; end
      4'd3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = 32'(sa / sb);
        r = 32'(sa % sb);
        return {r, q};
      end
      4'd4: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = a / b;
        r = a % b;
        return {r, q};
      end
      default: return 64'h0;
    endcase
  endfunction

  // Issue a multi-cycle op at the current negedge; entered and left at a negedge.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int n,
                        input int flush_at);
    logic [63:0] got;
    mdu.start = 1'b1; mdu.op = op; mdu.a = a; mdu.b = b; mdu.flush = 1'b0;
    exp_q.push_back(exp);
    @(negedge clk);
    mdu.start = 1'b0; mdu.op = 4'd0;
    mdu.a = $urandom; mdu.b = $urandom;
    for (int k = 0; k < n; k++) begin
      mdu.flush = (k == flush_at);
      chk({tag, "_busy"}, 64'(mdu.busy), 64'd1);
      if (k == n - 1) chk({tag, "_hold"}, {mdu.hi, mdu.lo}, model_hilo);
      @(negedge clk);
    end
    mdu.flush = 1'b0;
    chk({tag, "_done"}, 64'(mdu.busy), 64'd0);
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd1);
    end else begin
      got = exp_q.pop_front();
      chk({tag, "_hilo"}, {mdu.hi, mdu.lo}, got);
      model_hilo = got;
    end
  endtask

  // A start while busy must never happen.
  always @(posedge clk) begin
    if (rst_n && mdu.start && mdu.busy) begin
      assert (0) else begin
        failures++;
        $error("FAIL start_in_run observed=1 expected=0");
      end
    end
  end

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    checks = 0; failures = 0; model_hilo = 64'h0;
    mdu.start = 1'b0; mdu.op = 4'd0; mdu.flush = 1'b0; mdu.a = '0; mdu.b = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_busy", 64'(mdu.busy), 64'd0);
    chk("reset_hilo", {mdu.hi, mdu.lo}, 64'h0);

    run_op("mult", 4'd1, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, MC, -1);
    run_op("multu", 4'd2, 32'hFFFF_FFFE, 32'd3, 64'h0000_0002_FFFF_FFFA, MC, -1);
    run_op("div_neg", 4'd3, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, DC, -1);
    run_op("divu_zero", 4'd4, 32'd7, 32'd0, 64'h0000_0007_FFFF_FFFF, DC, -1);
    run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, DC, -1);
    run_op("div_zero", 4'd3, 32'd5, 32'd0, 64'h0000_0005_FFFF_FFFF, DC, -1);

    // mthi then mtlo back to back
    mdu.start = 1'b1; mdu.op = 4'd5; mdu.a = 32'h1234_5678;
    @(negedge clk);
    chk("mthi_hi", 64'(mdu.hi), 64'h1234_5678);
    chk("mthi_busy", 64'(mdu.busy), 64'd0);
    mdu.op = 4'd6; mdu.a = 32'h9ABC_DEF0;
    @(negedge clk);
    mdu.start = 1'b0; mdu.op = 4'd0;
    chk("mtlo_hilo", {mdu.hi, mdu.lo}, 64'h1234_5678_9ABC_DEF0);
    chk("mtlo_busy", 64'(mdu.busy), 64'd0);
    model_hilo = 64'h1234_5678_9ABC_DEF0;

    // start killed by flush in the same cycle
    mdu.start = 1'b1; mdu.flush = 1'b1; mdu.op = 4'd1; mdu.a = 32'd9; mdu.b = 32'd9;
    @(negedge clk);
    mdu.start = 1'b0; mdu.flush = 1'b0; mdu.op = 4'd0;
    chk("flush_busy", 64'(mdu.busy), 64'd0);
    repeat (MC) @(negedge clk);
    chk("flush_hilo", {mdu.hi, mdu.lo}, model_hilo);

    // flush during RUN does not cancel
    run_op("flush_run", 4'd1, 32'd100, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FF9C, MC, 2);

    // accumulate: {hi,lo} = 0x0_FFFFFFFF then maddu 1*1
    mdu.start = 1'b1; mdu.op = 4'd5; mdu.a = 32'h0;
    @(negedge clk);
    mdu.op = 4'd6; mdu.a = 32'hFFFF_FFFF;
    @(negedge clk);
    mdu.start = 1'b0; mdu.op = 4'd0;
    model_hilo = 64'h0000_0000_FFFF_FFFF;
    chk("madd_pre", {mdu.hi, mdu.lo}, model_hilo);
`ifdef MDU_MADD_EN
    run_op("maddu", 4'd8, 32'd1, 32'd1, 64'h0000_0001_0000_0000, MC, -1);
    run_op("msub", 4'd9, 32'd2, 32'hFFFF_FFFF, 64'h0000_0001_0000_0002, MC, -1);
`else
    mdu.start = 1'b1; mdu.op = 4'd8; mdu.a = 32'd1; mdu.b = 32'd1;
    @(negedge clk);
    mdu.start = 1'b0; mdu.op = 4'd0;
    chk("maddu_off_busy", 64'(mdu.busy), 64'd0);
    repeat (MC) @(negedge clk);
    chk("maddu_off_hilo", {mdu.hi, mdu.lo}, model_hilo);
    chk("maddu_off_busy2", 64'(mdu.busy), 64'd0);
`endif

    // randomized ops against the reference model
    for (int i = 0; i < 6; i++) begin
      rop = 4'($urandom_range(1, 4));
      ra  = $urandom;
      rb  = (i == 3) ? 32'd0 : ((i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom);
      run_op("rand", rop, ra, rb, ref_model(rop, ra, rb),
             (rop >= 4'd3) ? DC : MC, -1);
    end

    // make HI/LO nonzero, then reset mid-div: immediate clear, no later commit
    run_op("pre_reset", 4'd2, 32'd3, 32'd5, 64'h0000_0000_0000_000F, MC, -1);
    mdu.start = 1'b1; mdu.op = 4'd4; mdu.a = 32'd100; mdu.b = 32'd7;
    @(negedge clk);
    mdu.start = 1'b0; mdu.op = 4'd0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 64'(mdu.busy), 64'd0);
    chk("rst_mid_hilo", {mdu.hi, mdu.lo}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (DC + 2) @(negedge clk);
    chk("rst_nocommit_hilo", {mdu.hi, mdu.lo}, 64'h0);
    chk("rst_nocommit_busy", 64'(mdu.busy), 64'd0);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
